// File: rtl/channel_split_fifo_if.sv
// Valid/data-ack channel bundle: master drives d/v, slave drives the ack.
interface channel_split_fifo_if #(
    parameter int N = 8
);
    logic [N-1:0] d;
    logic         v;
    logic         a;

    modport master (output d, output v, input a);
    modport slave  (input d, input v, output a);
endinterface

// File: rtl/channel_split_fifo.sv
// Routes one input channel to out0/out1 by a masked code compare, each route buffered by its own FIFO.
// Optional CHANNEL_SPLIT_STATS_EN adds saturating per-route accept counters count0/count1.
module channel_split_fifo #(
    parameter int          N      = -1,
    parameter logic [N-1:0] Mask  = '0,
    parameter logic [N-1:0] Code0 = '0,
    parameter int          Depth  = 4,
    parameter int          CountW = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    channel_split_fifo_if.slave     in,
    channel_split_fifo_if.master    out0,
    channel_split_fifo_if.master    out1
`ifdef CHANNEL_SPLIT_STATS_EN
    ,
    output logic [CountW-1:0]       count0,
    output logic [CountW-1:0]       count1
`endif
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned OW = AW + 1;

    // Elaboration-time parameter sanity checks.
    if (N < 1) begin : g_bad_n
        $error("channel_split_fifo: N must be overridden with a value >= 1");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("channel_split_fifo: Depth must be a power of 2, >= 2");
    end
    if (CountW < 1) begin : g_bad_countw
        $error("channel_split_fifo: CountW must be >= 1");
    end

    logic         sel0;
    logic [1:0]   full;
    logic [1:0]   nonempty;
    logic [1:0]   push;
    logic [1:0]   pop;
    logic [1:0]   oack;
    logic [N-1:0] rdata [2];

    assign sel0 = ((in.d & Mask) == Code0);

    // Acceptance looks only at the target FIFO, never at the sinks' acks.
    assign in.a = in.v & ~reset & ~(sel0 ? full[0] : full[1]);

    assign push = {in.a & ~sel0, in.a & sel0};
    assign oack = {out1.a, out0.a};
    assign pop  = nonempty & oack;

    for (genvar k = 0; k < 2; k++) begin : g_fifo
        logic [N-1:0]  mem [Depth];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [OW-1:0] occ;

        // Storage is deliberately left out of reset.
        always_ff @(posedge clk) begin
            if (push[k]) begin
                mem[wr_ptr] <= in.d;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push[k]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop[k]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push[k], pop[k]})
                    2'b10:   occ <= occ + OW'(1);
                    2'b01:   occ <= occ - OW'(1);
                    default: occ <= occ;
                endcase
            end
        end

        assign full[k]     = (occ == OW'(Depth));
        assign nonempty[k] = (occ != '0);
        assign rdata[k]    = mem[rd_ptr];
    end

    assign out0.v = nonempty[0];
    assign out0.d = rdata[0];
    assign out1.v = nonempty[1];
    assign out1.d = rdata[1];

`ifdef CHANNEL_SPLIT_STATS_EN
    logic [CountW-1:0] cnt [2];

    // Per-route accept counters, saturating at all-ones.
    for (genvar k = 0; k < 2; k++) begin : g_stats
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt[k] <= '0;
            end else if (push[k] && (cnt[k] != {CountW{1'b1}})) begin
                cnt[k] <= cnt[k] + CountW'(1);
            end
        end
    end

    assign count0 = cnt[0];
    assign count1 = cnt[1];
`endif

endmodule

// File: tb/tb_channel_split_fifo.sv
// Bench for channel_split_fifo: hand-derived vector table, directed corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_channel_split_fifo;

    localparam int          N     = 8;
    localparam logic [7:0]  MASK  = 8'h80;
    localparam logic [7:0]  CODE0 = 8'h00;
    localparam int          DEPTH = 4;
    localparam int          CW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    channel_split_fifo_if #(.N(N)) in_if ();
    channel_split_fifo_if #(.N(N)) o0_if ();
    channel_split_fifo_if #(.N(N)) o1_if ();

`ifdef CHANNEL_SPLIT_STATS_EN
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
`endif

    channel_split_fifo #(
        .N(N), .Mask(MASK), .Code0(CODE0), .Depth(DEPTH), .CountW(CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_if),
        .out0   (o0_if),
        .out1   (o1_if)
`ifdef CHANNEL_SPLIT_STATS_EN
        ,
        .count0 (count0),
        .count1 (count1)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per route plus saturating accept counts.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         mc0 = 0;
    int         mc1 = 0;
    localparam int CMAX = (1 << CW) - 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic a0, input logic a1,
                         input logic r);
        in_if.v = v;
        in_if.d = d;
        o0_if.a = a0;
        o1_if.a = a1;
        reset   = r;
    endtask

    // Called just after a negedge with inputs driven: checks, then advances one clock.
    task automatic model_step(output logic accepted);
        logic to0, exp_a;
        int   tq;
        #1;
        to0   = ((in_if.d & MASK) == CODE0);
        tq    = to0 ? q0.size() : q1.size();
        exp_a = !reset && in_if.v && (tq < DEPTH);
        chk("in_a", 32'(in_if.a), 32'(exp_a));
        chk("out0_v", 32'(o0_if.v), 32'(q0.size() != 0));
        chk("out1_v", 32'(o1_if.v), 32'(q1.size() != 0));
        if (q0.size() != 0) chk("out0_d", 32'(o0_if.d), 32'(q0[0]));
        if (q1.size() != 0) chk("out1_d", 32'(o1_if.d), 32'(q1[0]));
`ifdef CHANNEL_SPLIT_STATS_EN
        chk("count0", 32'(count0), 32'(mc0));
        chk("count1", 32'(count1), 32'(mc1));
`endif
        accepted = exp_a;
        @(posedge clk);
        if (reset) begin
            q0.delete();
            q1.delete();
            mc0 = 0;
            mc1 = 0;
        end else begin
            if (o0_if.a && q0.size() != 0) void'(q0.pop_front());
            if (o1_if.a && q1.size() != 0) void'(q1.pop_front());
            if (exp_a) begin
                if (to0) begin
                    q0.push_back(in_if.d);
                    if (mc0 < CMAX) mc0++;
                end else begin
                    q1.push_back(in_if.d);
                    if (mc1 < CMAX) mc1++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic a0, input logic a1,
                        input logic r);
        logic acc;
        drive(v, d, a0, a1, r);
        model_step(acc);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a0;
        logic       a1;
        logic       ina;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
    } vec_t;

    vec_t vt[16];

    initial begin
        logic       acc;
        logic       pv;
        logic [7:0] pd;

        // Basic routing, then out1 stall to full, then drain with the held fifth word.
        vt[0]  = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 8'h85, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h85};
        vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        vt[4]  = '{1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
        vt[5]  = '{1'b1, 8'h82, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81};
        vt[6]  = '{1'b1, 8'h83, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81};
        vt[7]  = '{1'b1, 8'h84, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h81};
        vt[8]  = '{1'b1, 8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h81};
        vt[9]  = '{1'b1, 8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h81};
        vt[10] = '{1'b1, 8'h85, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h81};
        vt[11] = '{1'b1, 8'h85, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h82};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h83};
        vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h84};
        vt[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h85};
        vt[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

        // Unchecked first reset edge to leave the X state.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        step(1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].v, vt[i].d, vt[i].a0, vt[i].a1, 1'b0);
            #1;
            chk($sformatf("vec%0d_in_a", i), 32'(in_if.a), 32'(vt[i].ina));
            chk($sformatf("vec%0d_out0_v", i), 32'(o0_if.v), 32'(vt[i].v0));
            chk($sformatf("vec%0d_out1_v", i), 32'(o1_if.v), 32'(vt[i].v1));
            if (vt[i].v0) chk($sformatf("vec%0d_out0_d", i), 32'(o0_if.d), 32'(vt[i].d0));
            if (vt[i].v1) chk($sformatf("vec%0d_out1_d", i), 32'(o1_if.d), 32'(vt[i].d1));
            model_step(acc);
        end

        // Steady push+pop at occ=2 for 10 cycles on route 0; pointers wrap.
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b1, 1'b1, 1'b0);
            chk("occ2_out0_v", 32'(o0_if.v), 32'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Mid-operation reset with three words in each FIFO.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
            step(1'b1, 8'(8'hb0 + i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h41, 1'b1, 1'b1, 1'b0);
        #1;
        chk("post_reset_out0_v", 32'(o0_if.v), 32'd0);
        chk("post_reset_out1_v", 32'(o1_if.v), 32'd0);
        model_step(acc);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        chk("post_reset_first_word", 32'(o0_if.d), 32'h41);
        model_step(acc);

`ifdef CHANNEL_SPLIT_STATS_EN
        // Saturation of count0 after 20 route-0 words.
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        chk("count0_sat", 32'(count0), 32'd15);
        chk("count1_zero", 32'(count1), 32'd0);
        model_step(acc);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        chk("count0_reset", 32'(count0), 32'd0);
        chk("count1_reset", 32'(count1), 32'd0);
        model_step(acc);
`endif

        // Randomized traffic; the source holds v/d until accepted.
        pv  = 1'b0;
        pd  = 8'h00;
        acc = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!pv || acc) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = 8'($urandom);
            end
            drive(pv, pd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 299) == 0));
            model_step(acc);
            if (reset) acc = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
